uart_tx_generator: RTL and testbench



---
 rtl/uart_tx_generator.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_tx_generator.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_generator.sv
// UART transmitter with a small input FIFO: 8-bit LSB-first frames with optional
// parity, one or two stop bits and a runtime bit period, all latched per frame.
module uart_tx_generator #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic                          parity_en,
  input  logic                          parity_odd,
  input  logic                          two_stop,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             pop;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [2:0]       idx_q, idx_d;
  logic             stop2_q, stop2_d;
  logic [7:0]       data_q, data_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             par_en_q, par_en_d;
  logic             par_odd_q, par_odd_d;
  logic             two_stop_q, two_stop_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  // in_ready looks only at the registered count, so a full FIFO refuses writes even while popping
  assign in_ready   = (count_q != FULL_CNT);
  assign wr_en      = in_valid && in_ready;
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign bit_end    = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (wr_en && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!wr_en && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      stop2_q    <= 1'b0;
      data_q     <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      stop2_q    <= stop2_d;
      data_q     <= data_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Popping latches the head byte together with the frame format, so later config edits wait for the next pop
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    stop2_d    = stop2_q;
    data_d     = data_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    two_stop_d = two_stop_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          data_d     = mem[rd_ptr_q];
          div_d      = baud_div;
          par_en_d   = parity_en;
          par_odd_d  = parity_odd;
          two_stop_d = two_stop;
          timer_d    = baud_div;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          timer_d = div_q;
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = div_q;
          if (idx_q == 3'd7) begin
            state_d = par_en_q ? PARITY : STOP;
            stop2_d = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop2_d = 1'b0;
          timer_d = div_q;
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop2_q) begin
            stop2_d = 1'b1;
            timer_d = div_q;
          end else if (count_q != '0) begin
            pop        = 1'b1;
            data_d     = mem[rd_ptr_q];
            div_d      = baud_div;
            par_en_d   = parity_en;
            par_odd_d  = parity_odd;
            two_stop_d = two_stop;
            timer_d    = baud_div;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state values; done marks the cycle holding the last stop bit at timer 0
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (timer_d == '0) && (!two_stop_q || stop2_d);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[idx_d];
      PARITY:  tx_d = (^data_q) ^ par_odd_q;
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_generator.sv
// Directed self-checking bench for uart_tx_generator; expected frames are written
// out by hand as bit vectors (start at bit 0, stop bits at the top).
module tb_uart_tx_generator;

  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic             clk;
  logic             rst;
  logic [DIV_W-1:0] baud_div;
  logic             parity_en;
  logic             parity_odd;
  logic             two_stop;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic             tx;
  logic             busy;
  logic             done;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  int assertCount = 0;
  int failCount   = 0;
  logic [7:0] burst [5];

  uart_tx_generator #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W(DIV_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .baud_div(baud_div),
    .parity_en(parity_en),
    .parity_odd(parity_odd),
    .two_stop(two_stop),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx(tx),
    .busy(busy),
    .done(done),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic setConfig(input int div, input logic pen, input logic podd, input logic ts);
    baud_div   = DIV_W'(div);
    parity_en  = pen;
    parity_odd = podd;
    two_stop   = ts;
  endtask

  // Entered just after the edge that starts frame cycle 1; returns in the frame's last cycle
  task automatic checkFrame(input string tag, input int nbits, input logic [11:0] bits, input int div);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c <= div; c++) begin
        checkOutput($sformatf("%s tx bit%0d", tag, b), tx, bits[b]);
        checkOutput($sformatf("%s done bit%0d", tag, b), done, (b == nbits - 1 && c == div));
        if (!(b == nbits - 1 && c == div)) tick();
      end
    end
  endtask

  task automatic waitDone(input string tag, input int maxCycles);
    int n = 0;
    while (done !== 1'b1 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput(tag, done, 1);
  endtask

  initial begin
    burst[0] = 8'h21;
    burst[1] = 8'h32;
    burst[2] = 8'h43;
    burst[3] = 8'h54;
    burst[4] = 8'h65;
    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    setConfig(3, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    checkOutput("reset tx", tx, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset count", fifo_count, 0);
    checkOutput("reset in_ready", in_ready, 1);

    // Basic frame: 0xA5, 4 cycles per bit, 40-cycle frame
    applyStimulus(8'hA5);
    checkOutput("basic count after write", fifo_count, 1);
    checkOutput("basic tx before start", tx, 1);
    checkOutput("basic busy before start", busy, 0);
    tick();
    checkOutput("basic busy", busy, 1);
    checkOutput("basic count after pop", fifo_count, 0);
    checkFrame("basic", 10, {1'b1, 8'hA5, 1'b0}, 3);
    tick();
    checkOutput("basic busy after", busy, 0);
    checkOutput("basic done after", done, 0);
    checkOutput("basic tx after", tx, 1);

    // Parity: 0x07 even then odd, 22-cycle frames
    setConfig(1, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h07);
    tick();
    checkFrame("par even", 11, {1'b1, 1'b1, 8'h07, 1'b0}, 1);
    tick();
    checkOutput("par even idle", busy, 0);
    setConfig(1, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h07);
    tick();
    checkFrame("par odd", 11, {1'b1, 1'b0, 8'h07, 1'b0}, 1);
    tick();
    checkOutput("par odd idle", busy, 0);

    // Two stop bits at full rate: 0 for 9 cycles then 1 for 2
    setConfig(0, 1'b0, 1'b0, 1'b1);
    applyStimulus(8'h00);
    tick();
    checkFrame("two stop", 11, {1'b1, 1'b1, 8'h00, 1'b0}, 0);
    tick();
    checkOutput("two stop idle", busy, 0);
    checkOutput("two stop tx idle", tx, 1);

    // Full FIFO with a burst of 5 during a frame, then back-to-back frames
    setConfig(1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h11);
    tick();
    checkOutput("burst first start", tx, 0);
    for (int i = 0; i < 5; i++) begin
      in_data  = burst[i];
      in_valid = 1'b1;
      checkOutput($sformatf("burst in_ready %0d", i), in_ready, (i < 4));
      tick();
      checkOutput($sformatf("burst count %0d", i), fifo_count, (i < 4) ? i + 1 : 4);
    end
    in_valid = 1'b0;
    waitDone("burst first done", 40);
    checkOutput("burst count at first done", fifo_count, 4);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("burst count start %0d", i), fifo_count, 3 - i);
      checkOutput($sformatf("burst busy %0d", i), busy, 1);
      checkFrame($sformatf("burst frame %0d", i), 10, {1'b1, burst[i], 1'b0}, 1);
      checkOutput($sformatf("burst count end %0d", i), fifo_count, 3 - i);
      tick();
    end
    checkOutput("burst drained busy", busy, 0);
    checkOutput("burst drained tx", tx, 1);
    checkOutput("burst drained count", fifo_count, 0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("burst 5th ignored", busy, 0);

    // Reset mid-frame during DATA with 2 bytes queued
    setConfig(3, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h5A);
    tick();
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("rstmid count queued", fifo_count, 2);
    checkOutput("rstmid data bit0", tx, 0);
    checkOutput("rstmid busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstmid tx", tx, 1);
    checkOutput("rstmid busy after", busy, 0);
    checkOutput("rstmid count", fifo_count, 0);
    checkOutput("rstmid done", done, 0);
    for (int i = 0; i < 50; i++) begin
      tick();
      checkOutput($sformatf("rstmid quiet done %0d", i), done, 0);
      checkOutput($sformatf("rstmid quiet tx %0d", i), tx, 1);
    end
    applyStimulus(8'h3C);
    tick();
    checkFrame("rstmid fresh", 10, {1'b1, 8'h3C, 1'b0}, 3);
    tick();
    checkOutput("rstmid fresh idle", busy, 0);

    // Mid-frame config change; the queued byte picks up the new format at its pop
    setConfig(1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h81);
    in_data  = 8'h42;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checkOutput("cfg write+pop count", fifo_count, 1);
    setConfig(2, 1'b1, 1'b1, 1'b0);
    checkFrame("cfg old", 10, {1'b1, 8'h81, 1'b0}, 1);
    tick();
    checkOutput("cfg count next", fifo_count, 0);
    checkFrame("cfg new", 11, {1'b1, 1'b1, 8'h42, 1'b0}, 2);
    tick();
    checkOutput("cfg idle", busy, 0);
    checkOutput("cfg tx idle", tx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
